// File: rtl/vga_frame_checker_if.sv
// Video-under-test and frame-result bundle for vga_frame_checker.
// master: the raster source / harness side; slave: the checker.
interface vga_frame_checker_if;
  localparam int unsigned RGB_W = 3;
  localparam int unsigned CRC_W = 16;
  localparam int unsigned ERR_W = 4;
  localparam int unsigned CNT_W = 8;

  logic             hsync;
  logic             vsync;
  logic [RGB_W-1:0] rgb;
  logic             locked;
  logic             frame_done;
  logic [CRC_W-1:0] frame_crc;
  logic [ERR_W-1:0] err_flags;
  logic [CNT_W-1:0] err_count;

  modport master (
    output hsync, vsync, rgb,
    input  locked, frame_done, frame_crc, err_flags, err_count
  );

  modport slave (
    input  hsync, vsync, rgb,
    output locked, frame_done, frame_crc, err_flags, err_count
  );
endinterface

// File: rtl/vga_frame_checker.sv
// vga_frame_checker: samples hsync/vsync/rgb one pixel per clock, rebuilds the
// raster position from the sync edges, checks line length, hsync width, line
// count and blanking, and emits a per-frame 16-bit pixel signature.
// Optional feature macro: VGA_FRAME_CHECKER_PROBE_EN adds a single-pixel
// probe (probe_x/probe_y in, probe_rgb out).
module vga_frame_checker #(
  parameter int unsigned H_ACTIVE        = 640,
  parameter int unsigned H_TOTAL         = 800,
  parameter int unsigned H_SYNC_START    = 656,
  parameter int unsigned H_SYNC_LEN      = 96,
  parameter int unsigned V_ACTIVE        = 480,
  parameter int unsigned V_TOTAL         = 525,
  parameter int unsigned V_SYNC_START    = 490,
  parameter int unsigned V_SYNC_LEN      = 2,
  parameter bit          SYNC_ACTIVE_LOW = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
`ifdef VGA_FRAME_CHECKER_PROBE_EN
  input  logic [9:0]         probe_x,
  input  logic [9:0]         probe_y,
  output logic [2:0]         probe_rgb,
`endif
  vga_frame_checker_if.slave vif
);

  localparam int unsigned CW      = 10;
  localparam int unsigned RGB_W   = 3;
  localparam int unsigned CRC_W   = 16;
  localparam int unsigned ERR_W   = 4;
  localparam int unsigned CNT_W   = 8;
  localparam logic [CW-1:0]    CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] ECNT_MAX = '1;
  localparam logic [CRC_W-1:0] CRC_SEED = 16'hFFFF;
  localparam logic [CRC_W-1:0] CRC_POLY = 16'h1021;

  // Reject timing sets that cannot be represented by the 10-bit raster/counters.
  if ((H_SYNC_START + H_SYNC_LEN > H_TOTAL) || (V_SYNC_START + V_SYNC_LEN > V_TOTAL) ||
      (H_TOTAL > 1023) || (V_TOTAL > 1023) || (H_ACTIVE > H_SYNC_START) ||
      (V_ACTIVE > V_SYNC_START)) begin : g_bad_timing
    $error("vga_frame_checker: timing parameters out of range");
  end

  typedef enum logic [1:0] {
    ST_UNLOCKED,
    ST_ACQUIRE,
    ST_LOCKED
  } state_t;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == CNT_MAX) ? v : v + CW'(1);
  endfunction

  function automatic logic [CRC_W-1:0] crc_step(input logic [CRC_W-1:0] c,
                                                input logic [RGB_W-1:0] p);
    return {c[CRC_W-2:0], 1'b0} ^ (c[CRC_W-1] ? CRC_POLY : '0) ^ {13'b0, p};
  endfunction

  state_t           state;
  logic             hs_q, vs_q, hs_prev, vs_prev;
  logic [RGB_W-1:0] rgb_q, rgb_d;
  logic [CW-1:0]    x, y;
  logic [CW-1:0]    lcnt, hcnt, vcnt;
  logic [CRC_W-1:0] crc;
  logic [ERR_W-1:0] err_acc;

  logic             hs_edge, hs_fall, vs_edge;
  logic             x_wrap, active;
  logic [CW-1:0]    v_lines;
  logic [ERR_W-1:0] err_now, frame_errs;

  // Input capture with sync normalised to active-high; rgb_d lines up with x/y.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hs_q    <= 1'b0;
      vs_q    <= 1'b0;
      hs_prev <= 1'b0;
      vs_prev <= 1'b0;
      rgb_q   <= '0;
      rgb_d   <= '0;
    end else begin
      hs_q    <= SYNC_ACTIVE_LOW ? ~vif.hsync : vif.hsync;
      vs_q    <= SYNC_ACTIVE_LOW ? ~vif.vsync : vif.vsync;
      hs_prev <= hs_q;
      vs_prev <= vs_q;
      rgb_q   <= vif.rgb;
      rgb_d   <= rgb_q;
    end
  end

  // Edge detection, raster decode and per-cycle error terms.
  always_comb begin
    hs_edge = hs_q & ~hs_prev;
    hs_fall = ~hs_q & hs_prev;
    vs_edge = vs_q & ~vs_prev;
    x_wrap  = (x == CW'(H_TOTAL - 1));
    active  = (x < CW'(H_ACTIVE)) && (y < CW'(V_ACTIVE));
    // An hs edge on the closing cycle still belongs to the closing frame.
    v_lines = hs_edge ? sat_inc(vcnt) : vcnt;

    err_now    = '0;
    err_now[0] = hs_edge && (lcnt != CW'(H_TOTAL));
    err_now[1] = hs_fall && (hcnt != CW'(H_SYNC_LEN));
    err_now[2] = vs_edge && (v_lines != CW'(V_TOTAL));
    err_now[3] = !active && (rgb_d != '0);
    frame_errs = err_acc | err_now;
  end

  // Raster position rebuilt from sync edges; vs edge overrides line advance.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x <= '0;
      y <= '0;
    end else begin
      if (hs_edge) begin
        x <= CW'(H_SYNC_START);
      end else if (x_wrap) begin
        x <= '0;
      end else begin
        x <= x + CW'(1);
      end

      if (vs_edge) begin
        y <= CW'(V_SYNC_START);
      end else if (!hs_edge && x_wrap) begin
        y <= (y == CW'(V_TOTAL - 1)) ? '0 : y + CW'(1);
      end
    end
  end

  // Saturating measurement counters: line length, hsync run, lines per frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lcnt <= '0;
      hcnt <= '0;
      vcnt <= '0;
    end else begin
      lcnt <= hs_edge ? CW'(1) : sat_inc(lcnt);
      hcnt <= hs_q ? sat_inc(hcnt) : '0;
      if (vs_edge) begin
        vcnt <= '0;
      end else if (hs_edge) begin
        vcnt <= sat_inc(vcnt);
      end
    end
  end

  // Frame signature; the (0,0) pixel is folded into a fresh seed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      crc <= CRC_SEED;
    end else if ((x == '0) && (y == '0)) begin
      crc <= crc_step(CRC_SEED, rgb_d);
    end else if (active) begin
      crc <= crc_step(crc, rgb_d);
    end
  end

  // Lock FSM with registered frame results; runs on each vs leading edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= ST_UNLOCKED;
      err_acc        <= '0;
      vif.locked     <= 1'b0;
      vif.frame_done <= 1'b0;
      vif.frame_crc  <= '0;
      vif.err_flags  <= '0;
      vif.err_count  <= '0;
    end else begin
      vif.frame_done <= 1'b0;
      if (!vs_edge) begin
        err_acc <= frame_errs;
      end else begin
        err_acc <= '0;
        case (state)
          ST_ACQUIRE, ST_LOCKED: begin
            vif.frame_done <= 1'b1;
            vif.frame_crc  <= crc;
            vif.err_flags  <= frame_errs;
            if (frame_errs != '0) begin
              if (vif.err_count != ECNT_MAX) begin
                vif.err_count <= vif.err_count + CNT_W'(1);
              end
              state      <= (state == ST_LOCKED) ? ST_UNLOCKED : ST_ACQUIRE;
              vif.locked <= 1'b0;
            end else begin
              state      <= ST_LOCKED;
              vif.locked <= 1'b1;
            end
          end
          default: begin
            // First edge only marks a frame boundary; the partial frame is dropped.
            state      <= ST_ACQUIRE;
            vif.locked <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef VGA_FRAME_CHECKER_PROBE_EN
  // Single-pixel probe: latch the colour seen at the selected active position.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      probe_rgb <= '0;
    end else if (active && (x == probe_x) && (y == probe_y)) begin
      probe_rgb <= rgb_d;
    end
  end
`endif

endmodule

// File: tb/tb_vga_frame_checker.sv
// Scoreboard bench for vga_frame_checker using a reduced raster so that many
// frames fit in a short run. Expected frame results are queued when a frame is
// generated and compared when the checker pulses frame_done.
module tb_vga_frame_checker;

  localparam int HA  = 10;
  localparam int HT  = 16;
  localparam int HSS = 11;
  localparam int HSL = 3;
  localparam int VA  = 5;
  localparam int VT  = 8;
  localparam int VSS = 6;
  localparam int VSL = 1;

  localparam int K_CLEAN   = 0;
  localparam int K_PIXDIFF = 1;
  localparam int K_SHORT   = 2;
  localparam int K_BLANK   = 3;
  localparam int K_NARROW  = 4;

  typedef struct {
    logic [15:0] crc;
    logic [3:0]  errs;
    logic        locked;
    logic [7:0]  cnt;
  } exp_t;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;
  exp_t sb_q[$];
  int   m_state;
  int   m_cnt;

  vga_frame_checker_if vif();

`ifdef VGA_FRAME_CHECKER_PROBE_EN
  logic [2:0] probe_rgb;
`endif

  vga_frame_checker #(
    .H_ACTIVE(HA), .H_TOTAL(HT), .H_SYNC_START(HSS), .H_SYNC_LEN(HSL),
    .V_ACTIVE(VA), .V_TOTAL(VT), .V_SYNC_START(VSS), .V_SYNC_LEN(VSL),
    .SYNC_ACTIVE_LOW(1'b1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
`ifdef VGA_FRAME_CHECKER_PROBE_EN
    .probe_x   (10'd3),
    .probe_y   (10'd2),
    .probe_rgb (probe_rgb),
`endif
    .vif       (vif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] pix(input int kind, input int x, input int y);
    if (x < HA && y < VA) return (kind == K_PIXDIFF && x == 3 && y == 2) ? 3'b100 : 3'b001;
    return (kind == K_BLANK && x == 12 && y == 2) ? 3'b001 : 3'b000;
  endfunction

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [2:0] p);
    return {c[14:0], 1'b0} ^ (c[15] ? 16'h1021 : 16'h0000) ^ {13'b0, p};
  endfunction

  function automatic logic [15:0] frame_sig(input int kind);
    logic [15:0] c = 16'hFFFF;
    for (int yy = 0; yy < VA; yy++)
      for (int xx = 0; xx < HA; xx++)
        c = crc_step(c, pix(kind, xx, yy));
    return c;
  endfunction

  function automatic logic [3:0] kind_errs(input int kind);
    case (kind)
      K_SHORT:  return 4'b0001;
      K_NARROW: return 4'b0010;
      K_BLANK:  return 4'b1000;
      default:  return 4'b0000;
    endcase
  endfunction

  task automatic check_outputs_zero(input string pfx);
    check_val({pfx, "_locked"},     32'(vif.locked),     32'd0);
    check_val({pfx, "_frame_done"}, 32'(vif.frame_done), 32'd0);
    check_val({pfx, "_frame_crc"},  32'(vif.frame_crc),  32'd0);
    check_val({pfx, "_err_flags"},  32'(vif.err_flags),  32'd0);
    check_val({pfx, "_err_count"},  32'(vif.err_count),  32'd0);
  endtask

  // Model of the lock state machine, evaluated once per vs leading edge.
  task automatic model_frame(input int kind, input bit do_reset);
    logic [3:0] errs;
    exp_t       e;
    errs = kind_errs(kind);
    if (do_reset) begin
      m_state = 0;
      m_cnt   = 0;
    end
    if (m_state == 0) begin
      m_state = 1;
    end else begin
      if (errs != 4'b0) begin
        if (m_cnt < 255) m_cnt++;
        m_state = (m_state == 2) ? 0 : 1;
      end else begin
        m_state = 2;
      end
      e.crc    = frame_sig(kind);
      e.errs   = errs;
      e.locked = (m_state == 2);
      e.cnt    = 8'(m_cnt);
      sb_q.push_back(e);
    end
  endtask

  // Generate one raster frame (active-low syncs), optionally with a reset mid-frame.
  task automatic drive_frame(input int kind, input bit do_reset);
    int hs_len;
    model_frame(kind, do_reset);
    for (int y = 0; y < VT; y++) begin
      hs_len = (kind == K_NARROW && y == 2) ? HSL - 1 : HSL;
      for (int x = 0; x < HT; x++) begin
        if (kind == K_SHORT && y == 2 && x == HA) continue;
        @(posedge clk);
        #1;
        if (do_reset && y == 3 && x == 5) begin
          reset = 1'b1;
          #1;
          check_outputs_zero("midreset");
        end
        if (do_reset && y == 3 && x == 7) reset = 1'b0;
        vif.hsync = !(x >= HSS && x < HSS + hs_len);
        vif.vsync = !(y >= VSS && y < VSS + VSL);
        vif.rgb   = pix(kind, x, y);
      end
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && vif.frame_done) begin
        if (sb_q.size() == 0) begin
          check_val("spurious_frame_done", 32'(vif.frame_done), 32'd0);
        end else begin
          e = sb_q.pop_front();
          check_val("frame_crc", 32'(vif.frame_crc), 32'(e.crc));
          check_val("err_flags", 32'(vif.err_flags), 32'(e.errs));
          check_val("locked",    32'(vif.locked),    32'(e.locked));
          check_val("err_count", 32'(vif.err_count), 32'(e.cnt));
        end
      end
    end
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    m_state   = 0;
    m_cnt     = 0;
    reset     = 1'b1;
    vif.hsync = 1'b1;
    vif.vsync = 1'b1;
    vif.rgb   = 3'b000;

    fork
      monitor();
      begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
      end
    join_none

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (2) @(negedge clk);
    check_outputs_zero("reset");

    // Acquire and lock on clean frames, then a one-pixel change.
    repeat (3) drive_frame(K_CLEAN, 1'b0);
    drive_frame(K_PIXDIFF, 1'b0);
    drive_frame(K_CLEAN, 1'b0);

    // Each single-fault frame drops lock; two clean frames relock.
    drive_frame(K_SHORT, 1'b0);
    repeat (2) drive_frame(K_CLEAN, 1'b0);
    drive_frame(K_BLANK, 1'b0);
    repeat (2) drive_frame(K_CLEAN, 1'b0);
    drive_frame(K_NARROW, 1'b0);
    repeat (2) drive_frame(K_CLEAN, 1'b0);

    // Reset while locked, then relock.
    drive_frame(K_CLEAN, 1'b1);
    drive_frame(K_CLEAN, 1'b0);

    // Long run of bad frames saturates the error counter.
    repeat (300) drive_frame(K_BLANK, 1'b0);

    repeat (HT * 2) @(posedge clk);
    @(negedge clk);
    check_val("err_count_saturated", 32'(vif.err_count), 32'd255);
    check_val("scoreboard_drained",  32'(sb_q.size()),   32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
